fifo_singleclock_multi_rd_port: RTL and testbench
=================================================

FIFO_SINGLECLOCK_MULTI_RD_PORT -- requirements
Module: fifo_singleclock_multi_rd_port

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 32, storage in words; power of two, >=2; other values SHALL cause $fatal at elaboration.
REQ-003 Parameter NUM_RD, default 2, number of independent read ports (1..8); other values SHALL cause $fatal.
REQ-004 Parameter PROG_FULL, default 0, prog_full threshold in words; 0 disables (prog_full tied 0); must be <= DEPTH.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 din  in  WIDTH  write data.
REQ-008 wr_en  in  1  write request.
REQ-009 full  out  1  no write accepted this cycle.
REQ-010 prog_full  out  1  occupancy >= PROG_FULL.
REQ-011 level  out  $clog2(DEPTH)+1  max occupancy over enabled ports.
REQ-012 port_en  in  NUM_RD  per-port runtime enable; disabled port takes no copy of data.
REQ-013 rd_en  in  NUM_RD  per-port read request.
REQ-014 dout  out  NUM_RD x WIDTH  per-port registered read data.
REQ-015 empty  out  NUM_RD  per-port no unread word.

Function
REQ-016 Every written word SHALL be delivered once, in order, on every port enabled at its write; storage freed only when all such ports read it.
REQ-017 Per-port occupancy count SHALL be $clog2(DEPTH)+1 bits; full = any enabled port count == DEPTH (full DEPTH usable, no slot wasted).
REQ-018 empty[i] = (count[i]==0) | ~port_en[i]; level and prog_full consider enabled ports only.
REQ-019 Write accepted iff wr_en & ~full; write while full SHALL be dropped, no state change.
REQ-020 Port i read accepted iff rd_en[i] & port_en[i] & ~empty[i]; other rd_en ignored.
REQ-021 Read latency one cycle: dout[i] updates at edge of accepted read; holds otherwise.
REQ-022 Same-cycle write and read on port i: count[i] unchanged, both pointers advance; allowed at any non-full, non-empty level.
REQ-023 Write while count[i]==0 and rd_en[i]: write accepted, read ignored; word readable next cycle (no fall-through).
REQ-024 Read at count==DEPTH frees a slot for the next cycle only; same-cycle write stays refused (full from registered state).
REQ-025 Pointers $clog2(DEPTH) bits, wrap modulo DEPTH without gap.
REQ-026 port_en[i]==0 at an edge: rd pointer[i] <= next write pointer, count[i] <= 0; pending words discarded for that port.
REQ-027 Re-enabled port SHALL deliver only words written in or after the first cycle port_en[i]==1.
REQ-028 All ports disabled: full=0, writes accepted and discarded, level=0.
REQ-029 Memory write and read ports SHALL be inferable as block RAM (synchronous read, no reset on array).

Reset
REQ-030 rst=1: pointers, counts, dout 0 at next edge; empty all 1, full 0, prog_full 0, level 0 from following cycle.
REQ-031 rst mid-operation discards all stored data; wr_en/rd_en during rst ignored.

Structure
REQ-032 No shared package; DEPTH-derived widths are local constants.
REQ-033 One sub-module fifo_rd_port_ctrl (read pointer, count, empty, enable/resync), instantiated NUM_RD times via generate.

Verification (WIDTH=8, DEPTH=4, NUM_RD=3, PROG_FULL=3, all enabled unless stated)
REQ-034 Write 0x11..0x44, no reads -> full=1 after 4th write, level=4, prog_full=1 after 3rd; 5th write 0x55 dropped.
REQ-035 Reads port 0 only until empty[0] -> full stays 1; then ports 1,2 read -> each dout sequence 0x11,0x22,0x33,0x44, full=0 when all read first word.
REQ-036 Simultaneous write+read on all ports for 10 cycles at level 2 across wrap -> level stays 2, data order intact.
REQ-037 port_en[2]=0 with 3 pending, write 0xA0, re-enable, write 0xB0 -> port 2 delivers only 0xB0; ports 0,1 unaffected; full ignores port 2 while disabled.
REQ-038 rst asserted with level=3 -> next cycle empty=3'b111, level=0, dout=0; later write 0x5A readable on all ports.

Source files
------------

// File: rtl/fifo_rd_port_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_rd_port_ctrl
//   Read-side bookkeeping for one port of the multi-read-port FIFO: read
//   pointer, occupancy count, empty flag and the enable/resync behaviour.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     port_en    in   runtime enable for this port
//     rd_en      in   read request for this port
//     wr_acc     in   a write is accepted into the shared memory this cycle
//     wr_ptr_nxt in   write pointer value after this cycle's write
//     rd_ptr     out  address of the next word this port will read
//     count      out  words written but not yet read by this port
//     empty      out  no readable word (or port disabled)
//     rd_acc     out  read accepted this cycle
// ---------------------------------------------------------------------------
module fifo_rd_port_ctrl #(
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          port_en,
    input  logic          rd_en,
    input  logic          wr_acc,
    input  logic [AW-1:0] wr_ptr_nxt,
    output logic [AW-1:0] rd_ptr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          rd_acc
);

    assign empty  = (count == '0) | ~port_en;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else if (!port_en) begin
            // A disabled port tracks the write pointer so that, once
            // re-enabled, it only sees words written from then on.
            rd_ptr <= wr_ptr_nxt;
            count  <= '0;
        end else begin
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_singleclock_multi_rd_port.sv
// ---------------------------------------------------------------------------
// fifo_singleclock_multi_rd_port
//   Single-clock FIFO with one write port and NUM_RD independent read ports.
//   Every word written is delivered once, in order, to each port that was
//   enabled when it was written; a slot is reused only after every such port
//   has consumed it.
//
//   Ports:
//     clk        in   clock, rising edge
//     rst        in   synchronous active-high reset
//     din        in   write data
//     wr_en      in   write request
//     full       out  write refused this cycle (any enabled port holds DEPTH)
//     prog_full  out  level >= PROG_FULL (0 when PROG_FULL == 0)
//     level      out  max occupancy over enabled ports
//     port_en    in   per-port runtime enable
//     rd_en      in   per-port read request
//     dout       out  per-port registered read data (1-cycle latency)
//     empty      out  per-port empty flag
// ---------------------------------------------------------------------------
module fifo_singleclock_multi_rd_port #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 32,
    parameter int NUM_RD    = 2,
    parameter int PROG_FULL = 0,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [WIDTH-1:0]             din,
    input  logic                         wr_en,
    output logic                         full,
    output logic                         prog_full,
    output logic [CW-1:0]                level,
    input  logic [NUM_RD-1:0]            port_en,
    input  logic [NUM_RD-1:0]            rd_en,
    output logic [NUM_RD-1:0][WIDTH-1:0] dout,
    output logic [NUM_RD-1:0]            empty
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "WIDTH must be >= 1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "DEPTH must be a power of two >= 2");
    end
    if (NUM_RD < 1 || NUM_RD > 8) begin : g_bad_num_rd
        $fatal(1, "NUM_RD must be in 1..8");
    end
    if (PROG_FULL < 0 || PROG_FULL > DEPTH) begin : g_bad_prog_full
        $fatal(1, "PROG_FULL must be in 0..DEPTH");
    end

    logic [WIDTH-1:0]           mem [DEPTH];
    logic [AW-1:0]              wr_ptr;
    logic [AW-1:0]              wr_ptr_nxt;
    logic                       wr_acc;
    logic [NUM_RD-1:0][AW-1:0]  rd_ptr;
    logic [NUM_RD-1:0][CW-1:0]  count;
    logic [NUM_RD-1:0]          rd_acc;

    // Full comes only from registered counts, so a read at DEPTH cannot let
    // a write through in the same cycle.
    always_comb begin
        full  = 1'b0;
        level = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            if (port_en[i] && count[i] == CW'(DEPTH))
                full = 1'b1;
            if (port_en[i] && count[i] > level)
                level = count[i];
        end
    end

    if (PROG_FULL == 0) begin : g_no_prog_full
        assign prog_full = 1'b0;
    end else begin : g_prog_full
        assign prog_full = (level >= CW'(PROG_FULL));
    end

    assign wr_acc     = wr_en & ~full & ~rst;
    assign wr_ptr_nxt = wr_ptr + {{(AW-1){1'b0}}, wr_acc};

    always_ff @(posedge clk) begin
        if (rst)
            wr_ptr <= '0;
        else
            wr_ptr <= wr_ptr_nxt;
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= din;
    end

    // Read and write never hit the same slot in one cycle: a port only reads
    // when count > 0 and a write only lands when no enabled port is at DEPTH.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RD; i++) begin
            if (rst)
                dout[i] <= '0;
            else if (rd_acc[i])
                dout[i] <= mem[rd_ptr[i]];
        end
    end

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd_port
        fifo_rd_port_ctrl #(
            .DEPTH (DEPTH)
        ) u_ctrl (
            .clk        (clk),
            .rst        (rst),
            .port_en    (port_en[g]),
            .rd_en      (rd_en[g]),
            .wr_acc     (wr_acc),
            .wr_ptr_nxt (wr_ptr_nxt),
            .rd_ptr     (rd_ptr[g]),
            .count      (count[g]),
            .empty      (empty[g]),
            .rd_acc     (rd_acc[g])
        );
    end

endmodule

// File: tb/tb_fifo_singleclock_multi_rd_port.sv
module tb_fifo_singleclock_multi_rd_port;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int NRD   = 3;
    localparam int PF    = 3;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [WIDTH-1:0]          din;
    logic                      wr_en;
    logic                      full;
    logic                      prog_full;
    logic [2:0]                level;
    logic [NRD-1:0]            port_en;
    logic [NRD-1:0]            rd_en;
    logic [NRD-1:0][WIDTH-1:0] dout;
    logic [NRD-1:0]            empty;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_singleclock_multi_rd_port #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NRD), .PROG_FULL(PF)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .full(full),
        .prog_full(prog_full), .level(level), .port_en(port_en),
        .rd_en(rd_en), .dout(dout), .empty(empty)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic [7:0] din;
        logic [2:0] pe;
        logic [2:0] rd;
        logic       full;
        logic       pf;
        logic [2:0] lvl;
        logic [2:0] empty;
        logic [23:0] dout;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic w, logic [7:0] d, logic [2:0] pe,
                                logic [2:0] rd, logic f, logic pf, logic [2:0] lv,
                                logic [2:0] em, logic [23:0] dq);
        vec_t v;
        v.rst = r; v.wr = w; v.din = d; v.pe = pe; v.rd = rd;
        v.full = f; v.pf = pf; v.lvl = lv; v.empty = em; v.dout = dq;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic step(int idx, vec_t v);
        @(negedge clk);
        rst = v.rst; wr_en = v.wr; din = v.din; port_en = v.pe; rd_en = v.rd;
        @(posedge clk);
        #1;
        chk("full",      idx, 32'(full),      32'(v.full));
        chk("prog_full", idx, 32'(prog_full), 32'(v.pf));
        chk("level",     idx, 32'(level),     32'(v.lvl));
        chk("empty",     idx, 32'(empty),     32'(v.empty));
        chk("dout",      idx, 32'(dout),      32'(v.dout));
    endtask

    initial begin
        logic [7:0] d;
        rst = 1'b1; wr_en = 1'b0; din = '0; port_en = 3'b111; rd_en = '0;

        //                 rst wr din    pe      rd      full pf lvl empty   dout
        tbl.push_back(mk(1, 0, 8'h00, 3'b111, 3'b000, 0, 0, 0, 3'b111, 24'h000000));
        // fill to full, fifth write dropped
        tbl.push_back(mk(0, 1, 8'h11, 3'b111, 3'b000, 0, 0, 1, 3'b000, 24'h000000));
        tbl.push_back(mk(0, 1, 8'h22, 3'b111, 3'b000, 0, 0, 2, 3'b000, 24'h000000));
        tbl.push_back(mk(0, 1, 8'h33, 3'b111, 3'b000, 0, 1, 3, 3'b000, 24'h000000));
        tbl.push_back(mk(0, 1, 8'h44, 3'b111, 3'b000, 1, 1, 4, 3'b000, 24'h000000));
        tbl.push_back(mk(0, 1, 8'h55, 3'b111, 3'b000, 1, 1, 4, 3'b000, 24'h000000));
        // drain port 0 only; full held by ports 1,2
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b001, 1, 1, 4, 3'b000, 24'h000011));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b001, 1, 1, 4, 3'b000, 24'h000022));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b001, 1, 1, 4, 3'b000, 24'h000033));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b001, 1, 1, 4, 3'b001, 24'h000044));
        // read of empty port ignored, write while full dropped
        tbl.push_back(mk(0, 1, 8'h66, 3'b111, 3'b001, 1, 1, 4, 3'b001, 24'h000044));
        // read at DEPTH with same-cycle write: write still refused
        tbl.push_back(mk(0, 1, 8'h66, 3'b111, 3'b110, 0, 1, 3, 3'b001, 24'h111144));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b110, 0, 0, 2, 3'b001, 24'h222244));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b110, 0, 0, 1, 3'b001, 24'h333344));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b110, 0, 0, 0, 3'b111, 24'h444444));
        // write into empty with read requested: no fall-through
        tbl.push_back(mk(0, 1, 8'h77, 3'b111, 3'b111, 0, 0, 1, 3'b000, 24'h444444));
        tbl.push_back(mk(0, 1, 8'h88, 3'b111, 3'b000, 0, 0, 2, 3'b000, 24'h444444));
        // streaming write+read on all ports at level 2 across pointer wrap
        for (int k = 0; k < 10; k++) begin
            d = (k == 0) ? 8'h77 : (k == 1) ? 8'h88 : 8'(8'h90 + k - 2);
            tbl.push_back(mk(0, 1, 8'(8'h90 + k), 3'b111, 3'b111, 0, 0, 2, 3'b000, {d, d, d}));
        end
        tbl.push_back(mk(0, 1, 8'h9A, 3'b111, 3'b000, 0, 1, 3, 3'b000, 24'h979797));
        // disable port 2 with 3 pending; write A0 while disabled
        tbl.push_back(mk(0, 1, 8'hA0, 3'b011, 3'b000, 1, 1, 4, 3'b100, 24'h979797));
        tbl.push_back(mk(0, 0, 8'h00, 3'b011, 3'b011, 0, 1, 3, 3'b100, 24'h979898));
        // re-enable and write B0
        tbl.push_back(mk(0, 1, 8'hB0, 3'b111, 3'b000, 1, 1, 4, 3'b000, 24'h979898));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b111, 0, 1, 3, 3'b100, 24'hB09999));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b011, 0, 0, 2, 3'b100, 24'hB09A9A));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b011, 0, 0, 1, 3'b100, 24'hB0A0A0));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b011, 0, 0, 0, 3'b111, 24'hB0B0B0));
        // reset at level 3, with write and reads requested during reset
        tbl.push_back(mk(0, 1, 8'hC1, 3'b111, 3'b000, 0, 0, 1, 3'b000, 24'hB0B0B0));
        tbl.push_back(mk(0, 1, 8'hC2, 3'b111, 3'b000, 0, 0, 2, 3'b000, 24'hB0B0B0));
        tbl.push_back(mk(0, 1, 8'hC3, 3'b111, 3'b000, 0, 1, 3, 3'b000, 24'hB0B0B0));
        tbl.push_back(mk(1, 1, 8'hDD, 3'b111, 3'b111, 0, 0, 0, 3'b111, 24'h000000));
        tbl.push_back(mk(0, 1, 8'h5A, 3'b111, 3'b000, 0, 0, 1, 3'b000, 24'h000000));
        tbl.push_back(mk(0, 0, 8'h00, 3'b111, 3'b111, 0, 0, 0, 3'b111, 24'h5A5A5A));

        foreach (tbl[i]) step(i, tbl[i]);

        // all ports disabled: writes accepted but nobody keeps them
        step(100, mk(0, 1, 8'h33, 3'b000, 3'b000, 0, 0, 0, 3'b111, 24'h5A5A5A));
        step(101, mk(0, 1, 8'h44, 3'b000, 3'b111, 0, 0, 0, 3'b111, 24'h5A5A5A));
        step(102, mk(0, 1, 8'h55, 3'b111, 3'b000, 0, 0, 1, 3'b000, 24'h5A5A5A));
        step(103, mk(0, 0, 8'h00, 3'b111, 3'b111, 0, 0, 0, 3'b111, 24'h555555));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
